// File: rtl/rs_encoder_15_11_if.sv
// Symbol-stream bundle for the RS(15,11) encoder: message input handshake,
// codeword output stream and abort control.
interface rs_encoder_15_11_if #(
    parameter int SYM_W = 4
);
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] in_sym;
    logic             out_valid;
    logic [SYM_W-1:0] out_sym;
    logic [3:0]       out_idx;
    logic             out_last;
    logic             parity_ph;

    modport master (
        output abort, in_valid, in_sym,
        input  in_ready, out_valid, out_sym, out_idx, out_last, parity_ph
    );

    modport slave (
        input  abort, in_valid, in_sym,
        output in_ready, out_valid, out_sym, out_idx, out_last, parity_ph
    );
endinterface

// File: rtl/rs_encoder_15_11.sv
// Systematic RS(15,11) encoder over GF(16) (x^4+x+1). Message symbols pass
// straight through, then the four parity symbols P3..P0 are shifted out.
module rs_encoder_15_11 #(
    parameter int SYM_W = 4,
    parameter int N_SYM = 15,
    parameter int K_SYM = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    rs_encoder_15_11_if.slave  bus
);

    // g(x) = x^4 + D x^3 + C x^2 + 8 x + 7, packed low coefficient first
    localparam logic [15:0] G_COEF   = 16'hDC87;
    localparam logic [3:0]  LAST_MSG = 4'(K_SYM - 1);
    localparam logic [3:0]  LAST_IDX = 4'(N_SYM - 1);

    typedef enum logic {
        ST_MSG    = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    function automatic logic [3:0] gf_xtime(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    // Shift-and-add constant multiply; folds to a small XOR network per constant
    function automatic logic [3:0] gf_mul_const(input logic [3:0] a, input logic [3:0] c);
        logic [3:0] acc;
        logic [3:0] p;
        acc = 4'h0;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    state_t           state_reg, state_next;
    logic [3:0]       count_reg, count_next;
    logic [SYM_W-1:0] r_reg  [4];
    logic [SYM_W-1:0] r_next [4];
    logic             out_valid_reg, out_valid_next;
    logic [SYM_W-1:0] out_sym_reg, out_sym_next;
    logic [3:0]       out_idx_reg, out_idx_next;
    logic             out_last_reg, out_last_next;

    logic             in_ready;
    logic             accept;
    logic [SYM_W-1:0] fb;
    logic [SYM_W-1:0] fb_prod [4];

    assign in_ready = (state_reg == ST_MSG);
    assign accept   = bus.in_valid & in_ready;
    assign fb       = bus.in_sym ^ r_reg[3];

    for (genvar gi = 0; gi < 4; gi++) begin : g_fb_mul
        assign fb_prod[gi] = gf_mul_const(fb, G_COEF[gi*4 +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_MSG;
            count_reg     <= 4'd0;
            r_reg         <= '{default: '0};
            out_valid_reg <= 1'b0;
            out_sym_reg   <= '0;
            out_idx_reg   <= 4'd0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            r_reg         <= r_next;
            out_valid_reg <= out_valid_next;
            out_sym_reg   <= out_sym_next;
            out_idx_reg   <= out_idx_next;
            out_last_reg  <= out_last_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        r_next         = r_reg;
        out_valid_next = 1'b0;
        out_sym_next   = out_sym_reg;
        out_idx_next   = out_idx_reg;
        out_last_next  = 1'b0;

        if (bus.abort) begin
            // Abort outranks any accept or shift in the same cycle
            state_next = ST_MSG;
            count_next = 4'd0;
            r_next     = '{default: '0};
        end else begin
            case (state_reg)
                ST_MSG: begin
                    if (accept) begin
                        r_next[3]      = r_reg[2] ^ fb_prod[3];
                        r_next[2]      = r_reg[1] ^ fb_prod[2];
                        r_next[1]      = r_reg[0] ^ fb_prod[1];
                        r_next[0]      = fb_prod[0];
                        out_sym_next   = bus.in_sym;
                        out_idx_next   = count_reg;
                        out_valid_next = 1'b1;
                        count_next     = count_reg + 4'd1;
                        if (count_reg == LAST_MSG) state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    out_sym_next   = r_reg[3];
                    out_idx_next   = count_reg;
                    out_valid_next = 1'b1;
                    r_next[3]      = r_reg[2];
                    r_next[2]      = r_reg[1];
                    r_next[1]      = r_reg[0];
                    r_next[0]      = '0;
                    if (count_reg == LAST_IDX) begin
                        out_last_next = 1'b1;
                        state_next    = ST_MSG;
                        count_next    = 4'd0;
                    end else begin
                        count_next = count_reg + 4'd1;
                    end
                end
                default: begin
                    state_next = ST_MSG;
                    count_next = 4'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sym   = out_sym_reg;
    assign bus.out_idx   = out_idx_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.parity_ph = (state_reg == ST_PARITY);

endmodule

// File: tb/tb_rs_encoder_15_11.sv
// Directed and randomized bench for the RS(15,11) encoder: reference codewords,
// handshake gaps, syndrome checks, abort and mid-codeword reset.
module tb_rs_encoder_15_11;

    logic clk = 1'b0;
    logic rst_n;

    rs_encoder_15_11_if #(.SYM_W(4)) bus ();

    rs_encoder_15_11 #(.SYM_W(4), .N_SYM(15), .K_SYM(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [3:0] msg    [11];
    logic [3:0] exp_cw [15];
    logic [3:0] q_sym  [$];
    logic [3:0] q_idx  [$];
    bit         q_last [$];
    int         ready_low_cnt = 0;

    // Output monitor: records every valid codeword symbol just after the edge
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.out_valid) begin
            q_sym.push_back(bus.out_sym);
            q_idx.push_back(bus.out_idx);
            q_last.push_back(bus.out_last);
        end
    end

    always @(negedge clk) begin
        if (rst_n && !bus.in_ready) ready_low_cnt++;
    end

    function automatic logic [3:0] xt(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    task automatic clear_q();
        q_sym.delete();
        q_idx.delete();
        q_last.delete();
    endtask

    task automatic send_msg(input int n, input bit gap);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!bus.in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!bus.in_ready) begin
                chk_cnt++;
                $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", bus.in_ready, t);
            end
            bus.in_valid = 1'b1;
            bus.in_sym   = msg[i];
            @(negedge clk);
            if (gap) begin
                bus.in_valid = 1'b0;
                bus.in_sym   = 4'hF;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input string name);
        int t = 0;
        while (q_sym.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk_cnt++;
        if (q_sym.size() != n)
            $display("FAIL %s_count: got %0d outputs, required %0d", name, q_sym.size(), n);
        else
            pass_cnt++;
    endtask

    task automatic check_cw(input string name);
        for (int i = 0; i < 15; i++) begin
            chk_cnt++;
            if (i >= q_sym.size()) begin
                $display("FAIL %s[%0d]: missing output, required sym=%h idx=%0d", name, i, exp_cw[i], i);
            end else if (q_sym[i] !== exp_cw[i] || q_idx[i] !== 4'(i) || q_last[i] !== (i == 14)) begin
                $display("FAIL %s[%0d]: got sym=%h idx=%0d last=%0b, required sym=%h idx=%0d last=%0b",
                         name, i, q_sym[i], q_idx[i], q_last[i], exp_cw[i], i, (i == 14));
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic load_single(input logic [3:0] last_sym, input logic [3:0] p3, input logic [3:0] p2,
                               input logic [3:0] p1, input logic [3:0] p0);
        for (int i = 0; i < 10; i++) msg[i] = 4'h0;
        msg[10] = last_sym;
        for (int i = 0; i < 11; i++) exp_cw[i] = msg[i];
        exp_cw[11] = p3;
        exp_cw[12] = p2;
        exp_cw[13] = p1;
        exp_cw[14] = p0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sym   = 4'h0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({bus.out_valid, bus.out_sym, bus.out_idx, bus.out_last, bus.parity_ph} !== 11'b0)
            $display("FAIL reset_outputs: got valid=%0b sym=%h idx=%0d last=%0b ph=%0b, required all 0",
                     bus.out_valid, bus.out_sym, bus.out_idx, bus.out_last, bus.parity_ph);
        else
            pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_ready: got in_ready=%0b, required 1", bus.in_ready);
        else
            pass_cnt++;
    endtask

    task automatic test_zero_msg();
        load_single(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        clear_q();
        ready_low_cnt = 0;
        send_msg(11, 1'b0);
        wait_outputs(15, "zero");
        repeat (3) @(negedge clk);
        check_cw("zero");
        chk_cnt++;
        if (ready_low_cnt != 4)
            $display("FAIL zero_stall: in_ready low for %0d cycles, required 4", ready_low_cnt);
        else
            pass_cnt++;
    endtask

    task automatic test_unit_msg();
        load_single(4'h1, 4'hD, 4'hC, 4'h8, 4'h7);
        clear_q();
        send_msg(11, 1'b0);
        wait_outputs(15, "unit");
        check_cw("unit");
    endtask

    task automatic test_alpha_msg();
        load_single(4'h2, 4'h9, 4'hB, 4'h3, 4'hE);
        clear_q();
        send_msg(11, 1'b0);
        wait_outputs(15, "alpha");
        check_cw("alpha");
    endtask

    task automatic test_gaps();
        load_single(4'h1, 4'hD, 4'hC, 4'h8, 4'h7);
        clear_q();
        send_msg(11, 1'b1);
        wait_outputs(15, "gaps");
        check_cw("gaps");
    endtask

    task automatic test_back_to_back();
        int         bad_syn;
        int         bad_pass;
        logic [3:0] s;
        bad_syn  = 0;
        bad_pass = 0;
        for (int cw = 0; cw < 200; cw++) begin
            for (int i = 0; i < 11; i++) msg[i] = 4'($urandom_range(0, 15));
            clear_q();
            send_msg(11, 1'b0);
            wait_outputs(15, "rand");
            if (q_sym.size() == 15) begin
                for (int i = 0; i < 11; i++)
                    if (q_sym[i] !== msg[i]) bad_pass++;
                // Horner evaluation of c(x) at alpha^j, c[0] is the x^14 term
                for (int j = 1; j <= 4; j++) begin
                    s = 4'h0;
                    for (int i = 0; i < 15; i++) begin
                        for (int k = 0; k < j; k++) s = xt(s);
                        s = s ^ q_sym[i];
                    end
                    if (s !== 4'h0) bad_syn++;
                end
            end
        end
        chk_cnt++;
        if (bad_syn != 0)
            $display("FAIL rand_syndrome: %0d nonzero syndromes, required 0", bad_syn);
        else
            pass_cnt++;
        chk_cnt++;
        if (bad_pass != 0)
            $display("FAIL rand_passthru: %0d message mismatches, required 0", bad_pass);
        else
            pass_cnt++;
    endtask

    task automatic test_abort();
        for (int i = 0; i < 11; i++) msg[i] = 4'(i + 3);
        clear_q();
        send_msg(6, 1'b0);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sym   = 4'h9;
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk_cnt++;
        if (bus.out_valid !== 1'b0 || q_sym.size() != 6)
            $display("FAIL abort_drop: got out_valid=%0b outputs=%0d, required 0 and 6",
                     bus.out_valid, q_sym.size());
        else
            pass_cnt++;
        load_single(4'h1, 4'hD, 4'hC, 4'h8, 4'h7);
        clear_q();
        send_msg(11, 1'b0);
        wait_outputs(15, "abort");
        check_cw("abort");
    endtask

    task automatic test_reset_parity();
        int t = 0;
        for (int i = 0; i < 11; i++) msg[i] = 4'(15 - i);
        clear_q();
        send_msg(11, 1'b0);
        while (!bus.parity_ph && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.out_valid, bus.out_sym, bus.out_idx, bus.out_last, bus.parity_ph} !== 11'b0)
            $display("FAIL rstpar_outputs: got valid=%0b sym=%h idx=%0d last=%0b ph=%0b, required all 0",
                     bus.out_valid, bus.out_sym, bus.out_idx, bus.out_last, bus.parity_ph);
        else
            pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_single(4'h2, 4'h9, 4'hB, 4'h3, 4'hE);
        clear_q();
        send_msg(11, 1'b0);
        wait_outputs(15, "rstpar");
        check_cw("rstpar");
    endtask

    initial begin
        test_reset();
        test_zero_msg();
        test_unit_msg();
        test_alpha_msg();
        test_gaps();
        test_back_to_back();
        test_abort();
        test_reset_parity();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
